multicycle_ctrl: RTL

//  Control FSM for the multi-cycle build of the RV32I core. It sequences the

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// datapath, handshakes with a unified memory port, counts retired instructions, and traps.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic [RET_W-1:0] retired,
  output logic             halted,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [RET_W-1:0] retired_q;
  logic [WaitW-1:0] wait_q;
  logic             retire;
  logic             timeout;

  logic       legal, is_load, is_store, is_branch, use_imm;
  logic [2:0] imm_dec;
  logic [1:0] pc_src_wb, wb_sel_wb;

  always_comb begin
    legal     = 1'b1;
    imm_dec   = 3'd0;
    pc_src_wb = 2'd0;
    wb_sel_wb = 2'd0;
    use_imm   = 1'b0;
    unique case (opcode)
      OpR:      ;
      OpImm: begin
        imm_dec = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd5 : 3'd0;
        use_imm = 1'b1;
      end
      OpLoad: begin
        wb_sel_wb = 2'd1;
        use_imm   = 1'b1;
      end
      OpStore: begin
        imm_dec = 3'd1;
        use_imm = 1'b1;
      end
      OpBranch: imm_dec = 3'd2;
      OpJal: begin
        imm_dec   = 3'd3;
        pc_src_wb = 2'd1;
        wb_sel_wb = 2'd2;
      end
      OpJalr: begin
        pc_src_wb = 2'd2;
        wb_sel_wb = 2'd2;
        use_imm   = 1'b1;
      end
      OpLui: begin
        imm_dec   = 3'd4;
        wb_sel_wb = 2'd3;
      end
      OpAuipc: begin
        imm_dec = 3'd4;
        use_imm = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  // A ready arriving in the last permitted wait cycle beats the timeout.
  assign timeout   = (wait_q == WaitLast) && !mem_ready;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    imm_sel   = 3'd0;
    halted    = 1'b0;
    retire    = 1'b0;
    if (state_q inside {StDecode, StExec, StMem, StWb}) imm_sel = imm_dec;
    if (state_q inside {StExec, StMem, StWb}) begin
      alu_src_a = (opcode == OpAuipc);
      alu_src_b = use_imm;
    end
    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StDecode: state_d = legal ? StExec : StTrap;
      StExec: begin
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_load || is_store) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_src  = pc_src_wb;
        wb_sel  = wb_sel_wb;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap: halted = 1'b1;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + RET_W'(1);
      // Any state change clears the counter, covering entry to FETCH and MEM.
      if (state_d != state_q)          wait_q <= '0;
      else if (mem_req && !mem_ready)  wait_q <= wait_q + WaitW'(1);
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule
